// File: rtl/jk_latch_array.sv
// jk_latch_array
//   A bank of WIDTH independent JK storage cells that share one enable and
//   update once per rising clock edge. Because the cells are edge-triggered,
//   J=K=1 gives exactly one toggle per enabled cycle. A level-sensitive JK
//   latch would oscillate under the same inputs.
//
// Ports
//   clk        in   1      system clock, rising-edge active
//   rst_n      in   1      asynchronous reset, active-low
//   j          in   WIDTH  per-bit J (set)
//   k          in   WIDTH  per-bit K (reset)
//   enable     in   1      common enable; cells update only while high
//   q          out  WIDTH  stored state
//   q_bar      out  WIDTH  bitwise complement of q (combinational)
//   q_changed  out  WIDTH  one-cycle pulse per bit whose q changed on the last edge
//
// Parameters
//   WIDTH        number of cells (>=1)
//   RESET_VALUE  per-bit value of q while rst_n is low
module jk_latch_array #(
    parameter int                 WIDTH       = 1,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             enable,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic [WIDTH-1:0] q_changed
);

    logic [WIDTH-1:0] q_next;

    // Characteristic equation q+ = j&~q | ~k&q. It covers the four cases:
    //   hold (00), set (10), reset (01) and toggle (11).
    // When enable is low, every bit keeps its current value.
    always_comb begin
        q_next = q;
        if (enable) begin
            q_next = (j & ~q) | (~k & q);
        end
    end

    // q_changed is registered next to q, so it pulses in the cycle after the
    // edge that changed q. Reset clears q_changed, and it does not pulse for
    // the change that reset itself causes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q         <= RESET_VALUE;
            q_changed <= '0;
        end else begin
            q         <= q_next;
            q_changed <= q_next ^ q;
        end
    end

    assign q_bar = ~q;

endmodule

// File: tb/tb_jk_latch_array.sv
// Bench for jk_latch_array. It uses two instances: WIDTH=1 with reset value 0,
// and WIDTH=4 with reset value 4'b1010. A behavioural JK table produces the
// expected {q, q_bar, q_changed} whenever stimulus is driven. The expected
// value is queued at that point and popped after the next rising edge.
module tb_jk_latch_array;

    logic       clk;
    logic       rst_n;
    logic [0:0] j1, k1;
    logic       en1;
    logic [0:0] q1, qb1, qc1;
    logic [3:0] j4, k4;
    logic       en4;
    logic [3:0] q4, qb4, qc4;

    int total = 0;
    int bad   = 0;

    // Scoreboard entries: dut1 uses {9'b0, q, q_bar, q_changed}.
    // dut4 uses {q, q_bar, q_changed}.
    logic [11:0] exp_q[$];

    // Reference state for each instance.
    logic [3:0] m1_q, m1_c;
    logic [3:0] m4_q, m4_c;

    jk_latch_array #(.WIDTH(1), .RESET_VALUE(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .j(j1), .k(k1), .enable(en1),
        .q(q1), .q_bar(qb1), .q_changed(qc1)
    );

    jk_latch_array #(.WIDTH(4), .RESET_VALUE(4'b1010)) dut4 (
        .clk(clk), .rst_n(rst_n), .j(j4), .k(k4), .enable(en4),
        .q(q4), .q_bar(qb4), .q_changed(qc4)
    );

    // Clock and reset: 10-unit period, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Truth-table model of one JK cell.
    function automatic logic jk_model(input logic qo, input logic jj,
                                      input logic kk, input logic en);
        if (!en) return qo;
        case ({jj, kk})
            2'b00:   return qo;
            2'b10:   return 1'b1;
            2'b01:   return 1'b0;
            default: return ~qo;
        endcase
    endfunction

    task automatic check(input string tag, input logic [11:0] obs,
                         input logic [11:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m1_q = 4'b0000;
        m1_c = 4'b0000;
        m4_q = 4'b1010;
        m4_c = 4'b0000;
    endtask

    // Driver: apply inputs, push the predictions, wait for one edge, then
    // pop the predictions and compare them with the outputs.
    task automatic step(input string tag, input logic a_j, input logic a_k,
                        input logic a_en, input logic [3:0] b_j,
                        input logic [3:0] b_k, input logic b_en);
        logic [3:0] nq;
        j1 = a_j; k1 = a_k; en1 = a_en;
        j4 = b_j; k4 = b_k; en4 = b_en;

        nq    = m1_q;
        nq[0] = jk_model(m1_q[0], a_j, a_k, a_en);
        m1_c  = {3'b000, nq[0] != m1_q[0]};
        m1_q  = nq;
        exp_q.push_back({9'b0, m1_q[0], ~m1_q[0], m1_c[0]});

        for (int i = 0; i < 4; i++) begin
            nq[i]   = jk_model(m4_q[i], b_j[i], b_k[i], b_en);
            m4_c[i] = (nq[i] != m4_q[i]);
        end
        m4_q = nq;
        exp_q.push_back({m4_q, ~m4_q, m4_c});

        @(posedge clk);
        #1;
        check({tag, "_w1"}, {9'b0, q1, qb1, qc1}, exp_q.pop_front());
        check({tag, "_w4"}, {q4, qb4, qc4}, exp_q.pop_front());
    endtask

    initial begin
        rst_n = 1'b0;
        j1 = '0; k1 = '0; en1 = 1'b0;
        j4 = '0; k4 = '0; en4 = 1'b0;
        model_reset();

        // The reset values must hold even when clock edges arrive during reset.
        #22;
        check("in_reset_w1", {9'b0, q1, qb1, qc1}, {9'b0, 3'b010});
        check("in_reset_w4", {q4, qb4, qc4}, {4'b1010, 4'b0101, 4'b0000});

        // Release reset between edges.
        @(negedge clk);
        rst_n = 1'b1;

        step("idle_a", 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        step("idle_b", 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);

        // Set twice on dut1. Test the WIDTH=4 example vector on dut4.
        step("set1", 1'b1, 1'b0, 1'b1, 4'b0011, 4'b0110, 1'b1);
        step("set2", 1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0);

        // Reset, then toggle with enable held high.
        step("rst", 1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0);
        step("tog0", 1'b1, 1'b1, 1'b1, 4'hf, 4'hf, 1'b1);
        step("tog1", 1'b1, 1'b1, 1'b1, 4'hf, 4'hf, 1'b1);
        step("tog2", 1'b1, 1'b1, 1'b1, 4'hf, 4'hf, 1'b1);
        step("tog3", 1'b1, 1'b1, 1'b1, 4'hf, 4'hf, 1'b1);

        // With enable low, J=K=1 must leave q unchanged.
        for (int i = 0; i < 4; i++)
            step("dis_tog", 1'b1, 1'b1, 1'b0, 4'hf, 4'hf, 1'b0);

        // Reset a bank holding q=1, midway between edges.
        step("pre_rst", 1'b1, 1'b0, 1'b1, 4'b0101, 4'b0000, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst_w1", {9'b0, q1, qb1, qc1}, {9'b0, 3'b010});
        check("async_rst_w4", {q4, qb4, qc4}, {4'b1010, 4'b0101, 4'b0000});

        // While reset is low, a pending set must be ignored at the edge.
        j1 = 1'b1; k1 = 1'b0; en1 = 1'b1;
        j4 = 4'b0101; k4 = 4'b1010; en4 = 1'b1;
        @(posedge clk);
        #1;
        check("rst_hold_w1", {9'b0, q1, qb1, qc1}, {9'b0, 3'b010});
        check("rst_hold_w4", {q4, qb4, qc4}, {4'b1010, 4'b0101, 4'b0000});
        @(negedge clk);
        rst_n = 1'b1;

        // Random mix of inputs and enable values on both banks.
        for (int i = 0; i < 24; i++) begin
            step("rand",
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net in case the main sequence stalls.
    initial begin
        #100000;
        bad++;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
